// File: rtl/press_counter_pkg.sv
// Shared types and helpers for the press counter block.
package press_counter_pkg;

  // Double-press detector states.
  typedef enum logic {
    StIdle  = 1'b0,
    StArmed = 1'b1
  } press_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable pulse stretcher: out stays high for LEN cycles after the latest trig.
module pulse_stretch
  import press_counter_pkg::*;
#(
  parameter int unsigned LEN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);

  localparam int unsigned CW = cnt_w(LEN);

  logic [CW-1:0] cnt_q;

  // Reload on every trigger so a new press restarts the full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (trig) begin
      cnt_q <= CW'(LEN);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign out = (cnt_q != '0);

endmodule

// File: rtl/press_counter_leds.sv
// Press counter for the board LEDs: wrapping count, double-press and overflow pulses,
// and a press acknowledge LED. Define PRESS_COUNTER_STRETCH_EN to stretch led_ack over
// ACK_CYCLES; otherwise led_ack is a one-cycle registered copy of each press event.
module press_counter_leds
  import press_counter_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DBL_WINDOW = 6000000,
  parameter int unsigned ACK_CYCLES = 1200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             press,
  input  logic             clr,
  output logic [CNT_W-1:0] led,
  output logic             led_ack,
  output logic             dbl,
  output logic             ovf
);

  localparam int unsigned WW = cnt_w(DBL_WINDOW - 1);
  localparam logic [WW-1:0] WLast = WW'(DBL_WINDOW - 1);

  logic         press_q;
  logic         evt;
  press_state_e state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic         dbl_d;

  // Rising edge of press so a held button counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) press_q <= 1'b0;
    else     press_q <= press;
  end

  assign evt = press & ~press_q;

  // Wrapping press counter; clr wins over a coincident press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      led <= '0;
      ovf <= 1'b0;
    end else if (evt) begin
      led <= led + CNT_W'(1);
      ovf <= (led == '1);
    end else begin
      ovf <= 1'b0;
    end
  end

  // Double-press FSM state, window counter and registered dbl pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      dbl     <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      dbl     <= dbl_d;
    end
  end

  // Next-state: a press on the last window cycle still counts as a double.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    dbl_d   = 1'b0;
    if (clr) begin
      state_d = StIdle;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (evt) begin
            state_d = StArmed;
            wcnt_d  = '0;
          end
        end
        StArmed: begin
          if (evt) begin
            dbl_d   = 1'b1;
            state_d = StIdle;
            wcnt_d  = '0;
          end else if (wcnt_q == WLast) begin
            state_d = StIdle;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      endcase
    end
  end

`ifdef PRESS_COUNTER_STRETCH_EN
  pulse_stretch #(
    .LEN(ACK_CYCLES)
  ) u_ack (
    .clk (clk),
    .rst (rst),
    .trig(evt),
    .out (led_ack)
  );
`else
  logic ack_q;
  logic unused_ack_cfg;

  // One-cycle acknowledge per press; clr does not suppress it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= evt;
  end

  assign led_ack        = ack_q;
  assign unused_ack_cfg = (ACK_CYCLES != 0);
`endif

endmodule

// File: tb/tb_press_counter_leds.sv
// Bench for press_counter_leds: directed steps, reference model feeds a scoreboard queue.
module tb_press_counter_leds;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DBL_WINDOW = 10;
  localparam int unsigned ACK_CYCLES = 5;

  typedef struct packed {
    logic [CNT_W-1:0] led;
    logic             ack;
    logic             dbl;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             press = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] led;
  logic             led_ack;
  logic             dbl;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Reference model state.
  int unsigned m_led;
  bit          m_press_q;
  bit          m_armed;
  int unsigned m_w;
  int unsigned m_acnt;

  press_counter_leds #(
    .CNT_W     (CNT_W),
    .DBL_WINDOW(DBL_WINDOW),
    .ACK_CYCLES(ACK_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .press  (press),
    .clr    (clr),
    .led    (led),
    .led_ack(led_ack),
    .dbl    (dbl),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_led = 0; m_press_q = 0; m_armed = 0; m_w = 0; m_acnt = 0;
  endtask

  // Advance the model one clock with the given inputs and queue the expected outputs.
  task automatic model_step(input bit p, input bit c);
    exp_t e;
    bit evt;
    evt = p && !m_press_q;
    e = '0;
    if (c) begin
      m_led = 0; m_armed = 0; m_w = 0;
    end else begin
      if (evt) begin
        e.ovf = (m_led == 15);
        m_led = (m_led + 1) % 16;
      end
      if (!m_armed) begin
        if (evt) begin m_armed = 1; m_w = 0; end
      end else if (evt) begin
        e.dbl = 1'b1; m_armed = 0; m_w = 0;
      end else if (m_w == DBL_WINDOW - 1) begin
        m_armed = 0; m_w = 0;
      end else begin
        m_w++;
      end
    end
`ifdef PRESS_COUNTER_STRETCH_EN
    if (evt) m_acnt = ACK_CYCLES;
    else if (m_acnt != 0) m_acnt--;
    e.ack = (m_acnt != 0);
`else
    e.ack = evt;
`endif
    m_press_q = p;
    e.led = CNT_W'(m_led);
    sb.push_back(e);
  endtask

  // One cycle: drive, let the edge pass, compare against the scoreboard head.
  task automatic step(input bit p, input bit c);
    exp_t e;
    press = p;
    clr   = c;
    model_step(p, c);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("led", 32'(led), 32'(e.led));
    check("led_ack", 32'(led_ack), 32'(e.ack));
    check("dbl", 32'(dbl), 32'(e.dbl));
    check("ovf", 32'(ovf), 32'(e.ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_ack"}, 32'(led_ack), 32'd0);
    check({tag, "_dbl"}, 32'(dbl), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle(3);

    // Three isolated presses: count 1,2,3 with no double.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      check("single_led", 32'(led), 32'(k + 1));
      idle(19);
    end
    check("three_presses", 32'(led), 32'd3);

    // Held press counts once; ack stretch follows the first cycle.
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    check("held_once", 32'(led), 32'd4);
    idle(15);

    // Presses at T and T+4 -> double; T+30 only arms.
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    check("dbl_t4", 32'(dbl), 32'd1);
    idle(25);
    step(1'b1, 1'b0);
    check("dbl_t30", 32'(dbl), 32'd0);
    idle(15);

    // Last window cycle still counts as a double.
    step(1'b1, 1'b0);
    idle(9);
    step(1'b1, 1'b0);
    check("dbl_edge", 32'(dbl), 32'd1);
    idle(15);

    // One cycle past the window: no double, second press re-arms.
    step(1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b0);
    check("dbl_expired", 32'(dbl), 32'd0);
    idle(2);
    step(1'b1, 1'b0);
    check("dbl_rearmed", 32'(dbl), 32'd1);
    idle(15);

    // 16 presses from zero: wrap with ovf, coincident with dbl on the 16th.
    step(1'b0, 1'b1);
    check("clr_led", 32'(led), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0);
      idle(3);
    end
    check("wrap_led", 32'(led), 32'd0);
    idle(15);

    // clr with simultaneous press at led=7.
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0);
      idle(15);
    end
    check("at_seven", 32'(led), 32'd7);
    step(1'b1, 1'b1);
    check("clr_wins", 32'(led), 32'd0);
    idle(15);

    // Async reset mid-ARMED.
    step(1'b1, 1'b0);
    idle(2);
    rst = 1'b1;
    #2;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b0;
    idle(2);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b0);
    check("post_rst_dbl", 32'(dbl), 32'd1);
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
